// File: rtl/flappy_ctrl_seq_if.sv
// rtl/flappy_ctrl_seq_if.sv - reset/flap request and core control bundle for flappy_ctrl_seq
interface flappy_ctrl_seq_if;
  logic       osd_reset;
  logic       btn_reset;
  logic       fire_reset;
  logic       fire_flap;
  logic       key_reset_n;
  logic       key_flap_n;
  logic       core_reset_n;
  logic       flap_n;
  logic [1:0] state;

  modport master (
    output osd_reset, btn_reset, fire_reset, fire_flap, key_reset_n, key_flap_n,
    input  core_reset_n, flap_n, state
  );

  modport slave (
    input  osd_reset, btn_reset, fire_reset, fire_flap, key_reset_n, key_flap_n,
    output core_reset_n, flap_n, state
  );
endinterface

// File: rtl/flappy_ctrl_seq.sv
// rtl/flappy_ctrl_seq.sv - stretched core reset and flap sequencer for the Flappy Bird core
// Optional autofire in RUN is enabled by defining AUTOFLAP_EN.
module flappy_ctrl_seq #(
  parameter int HOLD_W     = 17,
  parameter int DEB_W      = 16,
  parameter int SETTLE_CYC = 1024,
  parameter int AUTO_W     = 22
) (
  input  logic              clk,
  input  logic              reset,
  flappy_ctrl_seq_if.slave  bus
);

  localparam int SET_W = $clog2(SETTLE_CYC + 1);
  localparam int CNT_W = (HOLD_W > SET_W) ? HOLD_W : SET_W;
  localparam logic [CNT_W-1:0] HOLD_MAX   = CNT_W'({HOLD_W{1'b1}});
  localparam logic [CNT_W-1:0] SETTLE_MAX = CNT_W'(SETTLE_CYC - 1);

  if (HOLD_W < 1 || DEB_W < 1 || SETTLE_CYC < 1 || AUTO_W < 2) begin : g_param_check
    $error("flappy_ctrl_seq: parameter out of range");
  end

  typedef enum logic [1:0] {
    S_HOLD   = 2'd0,
    S_SETTLE = 2'd1,
    S_RUN    = 2'd2
  } state_t;

  // Index 1 is KEY[1] (reset), index 0 is KEY[0] (flap); all idle high.
  logic [1:0]            key_raw;
  logic [1:0]            key_meta;
  logic [1:0]            key_sync;
  logic [1:0]            key_db;
  logic [1:0][DEB_W-1:0] deb_cnt;

  assign key_raw = {bus.key_reset_n, bus.key_flap_n};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      key_meta <= 2'b11;
      key_sync <= 2'b11;
      key_db   <= 2'b11;
      deb_cnt  <= '0;
    end else begin
      key_meta <= key_raw;
      key_sync <= key_meta;
      for (int i = 0; i < 2; i++) begin
        if (key_sync[i] == key_db[i]) begin
          deb_cnt[i] <= '0;
        end else if (deb_cnt[i] == {DEB_W{1'b1}}) begin
          deb_cnt[i] <= '0;
          key_db[i]  <= key_sync[i];
        end else begin
          deb_cnt[i] <= deb_cnt[i] + DEB_W'(1);
        end
      end
    end
  end

  logic req;
  logic flap_req;

  assign req      = bus.osd_reset | bus.btn_reset | bus.fire_reset | ~key_db[1];
  assign flap_req = bus.fire_flap | ~key_db[0];

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             core_q, core_d;
  logic             flap_q, flap_d;

`ifdef AUTOFLAP_EN
  logic [AUTO_W-1:0] phase_q, phase_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) phase_q <= '0;
    else       phase_q <= phase_d;
  end
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_HOLD;
      cnt_q   <= '0;
      core_q  <= 1'b0;
      flap_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      core_q  <= core_d;
      flap_q  <= flap_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    flap_d  = 1'b1;
`ifdef AUTOFLAP_EN
    phase_d = '0;
`endif
    if (req) begin
      state_d = S_HOLD;
      cnt_d   = '0;
    end else begin
      case (state_q)
        S_HOLD: begin
          if (cnt_q == HOLD_MAX) begin
            state_d = S_SETTLE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        S_SETTLE: begin
          // Saturate rather than leave while the flap is held, so a stuck button can't start a game.
          if (cnt_q == SETTLE_MAX) begin
            if (!flap_req) state_d = S_RUN;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        S_RUN: begin
`ifdef AUTOFLAP_EN
          if (flap_req) begin
            flap_d  = phase_q[AUTO_W-1];
            phase_d = phase_q + AUTO_W'(1);
          end
`else
          flap_d = ~flap_req;
`endif
        end
        default: begin
          state_d = S_HOLD;
          cnt_d   = '0;
        end
      endcase
    end
    core_d = (state_d != S_HOLD);
  end

  assign bus.core_reset_n = core_q;
  assign bus.flap_n       = flap_q;
  assign bus.state        = state_q;

endmodule
